// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480 @ 60 Hz timing defaults and the coordinate and
// colour channel types used by the VGA sync generator.
package vga_pkg;

    typedef logic [15:0] coord_t;
    typedef logic [3:0]  chan_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: clock-enable divider. Pixel_tick is high on the last Clk
// cycle of every group of CLK_DIV cycles.
//   Clk        in  : system clock
//   Rst_n      in  : asynchronous active-low reset
//   Pixel_tick out : one-Clk enable pulse per pixel
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    output logic Pixel_tick
);

    // At CLK_DIV=1 the counter is a single bit that never leaves 0, so the
    // tick is permanently high.
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign Pixel_tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator. Drives the pixel coordinate bus to the
// painter and registers the painter colour, sync and Video_on back out, so the
// pins lag the coordinates by exactly one pixel.
//   Clk, Rst_n                      in  : clock, async active-low reset
//   Red_in, Green_in, Blue_in       in  : painter colour for current Xpos/Ypos
//   Xpos, Ypos                      out : pixel coordinates
//   Pixel_tick, Frame_start         out : pixel enable, frame-wrap pulse
//   Video_on, Hsync, Vsync          out : registered pin-aligned timing
//   Red, Green, Blue                out : registered, blanked colour
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic   Clk,
    input  logic   Rst_n,
    input  chan_t  Red_in,
    input  chan_t  Green_in,
    input  chan_t  Blue_in,
    output coord_t Xpos,
    output coord_t Ypos,
    output logic   Pixel_tick,
    output logic   Frame_start,
    output logic   Video_on,
    output logic   Hsync,
    output logic   Vsync,
    output chan_t  Red,
    output chan_t  Green,
    output chan_t  Blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic active;
    logic hs;
    logic vs;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Pixel_tick(Pixel_tick)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Xpos <= '0;
            Ypos <= '0;
        end else if (Pixel_tick) begin
            if (Xpos == H_LAST) begin
                Xpos <= '0;
                Ypos <= (Ypos == V_LAST) ? '0 : Ypos + coord_t'(1);
            end else begin
                Xpos <= Xpos + coord_t'(1);
            end
        end
    end

    assign Frame_start = Pixel_tick && (Xpos == H_LAST) && (Ypos == V_LAST);

    assign active = (Xpos < H_ACT_C) && (Ypos < V_ACT_C);
    assign hs     = (Xpos >= HS_FIRST) && (Xpos <= HS_LAST);
    assign vs     = (Ypos >= VS_FIRST) && (Ypos <= VS_LAST);

    // Everything here describes the pixel just addressed, so the pins trail
    // the coordinate bus by one pixel and stay mutually aligned.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Video_on <= 1'b0;
            Hsync    <= ~SYNC_POL;
            Vsync    <= ~SYNC_POL;
            Red      <= '0;
            Green    <= '0;
            Blue     <= '0;
        end else if (Pixel_tick) begin
            Video_on <= active;
            Hsync    <= hs ? SYNC_POL : ~SYNC_POL;
            Vsync    <= vs ? SYNC_POL : ~SYNC_POL;
            Red      <= active ? Red_in   : '0;
            Green    <= active ? Green_in : '0;
            Blue     <= active ? Blue_in  : '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance A: full 640x480 timing
    logic   align = 1'b0;
    chan_t  rin_a = 4'hF, gin_a = 4'hF, bin_a = 4'hF;
    chan_t  red_in_a;
    coord_t xpos_a, ypos_a;
    logic   tick_a, fs_a, von_a, hs_a, vs_a;
    chan_t  red_a, green_a, blue_a;

    assign red_in_a = align ? xpos_a[3:0] : rin_a;

    vga_sync_gen u_dut_a (
        .Clk(clk), .Rst_n(rst_n),
        .Red_in(red_in_a), .Green_in(gin_a), .Blue_in(bin_a),
        .Xpos(xpos_a), .Ypos(ypos_a), .Pixel_tick(tick_a), .Frame_start(fs_a),
        .Video_on(von_a), .Hsync(hs_a), .Vsync(vs_a),
        .Red(red_a), .Green(green_a), .Blue(blue_a)
    );

    // instance B: shrunken timing (16x12 total) so whole frames fit the run
    // active 8, fp 2, sync 3 (x 10..12), bp 3 / active 6, fp 2, sync 2 (y 8..9), bp 2
    chan_t  rin_b = 4'hF, gin_b = 4'hF, bin_b = 4'hF;
    coord_t xpos_b, ypos_b;
    logic   tick_b, fs_b, von_b, hs_b, vs_b;
    chan_t  red_b, green_b, blue_b;

    vga_sync_gen #(
        .CLK_DIV(2),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0)
    ) u_dut_b (
        .Clk(clk), .Rst_n(rst_n),
        .Red_in(rin_b), .Green_in(gin_b), .Blue_in(bin_b),
        .Xpos(xpos_b), .Ypos(ypos_b), .Pixel_tick(tick_b), .Frame_start(fs_b),
        .Video_on(von_b), .Hsync(hs_b), .Vsync(vs_b),
        .Red(red_b), .Green(green_b), .Blue(blue_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Wait for the negedge sample where Pixel_tick is high at (x, y).
    task automatic wait_pix(input bit inst_b, input int x, input int y,
                            input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (inst_b) begin
                if (tick_b && xpos_b == x && ypos_b == y) begin ok = 1'b1; break; end
            end else begin
                if (tick_a && xpos_a == x && ypos_a == y) begin ok = 1'b1; break; end
            end
        end
    endtask

    // At a tick sample with coordinates (x, y), the pins show pixel x-1.
    typedef struct {
        int    x;
        int    y;
        chan_t rin;
        logic  von;
        logic  hs;
        logic  vs;
        chan_t red;
    } vec_t;

    vec_t va[10];
    vec_t vb[8];

    task automatic run_vec(input bit inst_b, input vec_t v, input string tag);
        bit ok;
        if (inst_b) rin_b = v.rin; else rin_a = v.rin;
        wait_pix(inst_b, v.x, v.y, 4000, ok);
        check({tag, " reached"}, int'(ok), 1);
        if (inst_b) begin
            check({tag, " video_on"}, int'(von_b), int'(v.von));
            check({tag, " hsync"},    int'(hs_b),  int'(v.hs));
            check({tag, " vsync"},    int'(vs_b),  int'(v.vs));
            check({tag, " red"},      int'(red_b), int'(v.red));
            check({tag, " green"},    int'(green_b), v.von ? 3 : 0);
        end else begin
            check({tag, " video_on"}, int'(von_a), int'(v.von));
            check({tag, " hsync"},    int'(hs_a),  int'(v.hs));
            check({tag, " vsync"},    int'(vs_a),  int'(v.vs));
            check({tag, " red"},      int'(red_a), int'(v.red));
            check({tag, " blue"},     int'(blue_a), v.von ? 12 : 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit     ok;
        int     cnt, bad, seen;
        coord_t tmp;

        va[0] = '{1,   0, 4'hA, 1'b1, 1'b1, 1'b1, 4'hA};
        va[1] = '{100, 0, 4'h5, 1'b1, 1'b1, 1'b1, 4'h5};
        va[2] = '{640, 0, 4'h5, 1'b1, 1'b1, 1'b1, 4'h5};
        va[3] = '{641, 0, 4'h5, 1'b0, 1'b1, 1'b1, 4'h0};
        va[4] = '{656, 0, 4'hA, 1'b0, 1'b1, 1'b1, 4'h0};
        va[5] = '{657, 0, 4'hA, 1'b0, 1'b0, 1'b1, 4'h0};
        va[6] = '{752, 0, 4'hA, 1'b0, 1'b0, 1'b1, 4'h0};
        va[7] = '{753, 0, 4'hA, 1'b0, 1'b1, 1'b1, 4'h0};
        va[8] = '{0,   1, 4'hA, 1'b0, 1'b1, 1'b1, 4'h0};
        va[9] = '{1,   1, 4'hC, 1'b1, 1'b1, 1'b1, 4'hC};

        vb[0] = '{8,  5, 4'hA, 1'b1, 1'b1, 1'b1, 4'hA};
        vb[1] = '{9,  5, 4'hA, 1'b0, 1'b1, 1'b1, 4'h0};
        vb[2] = '{11, 5, 4'hA, 1'b0, 1'b0, 1'b1, 4'h0};
        vb[3] = '{13, 5, 4'hA, 1'b0, 1'b0, 1'b1, 4'h0};
        vb[4] = '{14, 5, 4'hA, 1'b0, 1'b1, 1'b1, 4'h0};
        vb[5] = '{1,  6, 4'hA, 1'b0, 1'b1, 1'b1, 4'h0};
        vb[6] = '{1,  8, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0};
        vb[7] = '{1,  0, 4'hA, 1'b1, 1'b1, 1'b1, 4'hA};

        // reset with all-ones painter colour
        repeat (4) @(negedge clk);
        check("rst xpos",     int'(xpos_a), 0);
        check("rst ypos",     int'(ypos_a), 0);
        check("rst hsync",    int'(hs_a), 1);
        check("rst vsync",    int'(vs_a), 1);
        check("rst red",      int'(red_a), 0);
        check("rst green",    int'(green_a), 0);
        check("rst blue",     int'(blue_a), 0);
        check("rst video_on", int'(von_a), 0);
        check("rst tick",     int'(tick_a), 0);
        check("rst frame",    int'(fs_a), 0);
        check("rst b hsync",  int'(hs_b), 1);
        check("rst b red",    int'(red_b), 0);

        gin_a = 4'h3; bin_a = 4'hC; rin_a = 4'hA;
        gin_b = 4'h3; bin_b = 4'hC; rin_b = 4'hA;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(1'b0, va[i], $sformatf("A%0d", i));

        // hsync fall position and width on line 1
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (hs_a == 1'b0) begin ok = 1'b1; break; end
        end
        check("hs fall seen", int'(ok), 1);
        check("hs fall xpos", int'(xpos_a), 657);
        check("hs fall ypos", int'(ypos_a), 1);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cnt++;
            if (hs_a == 1'b1) break;
        end
        check("hs low clk cycles", cnt, 192);

        // alignment: painter echoes Xpos[3:0]
        align = 1'b1;
        wait_pix(1'b0, 1, 2, 400, ok);
        check("align start", int'(ok), 1);
        bad = 0; seen = 0; ok = 1'b0;
        for (int i = 0; i < 1400; i++) begin
            if (i > 0) @(negedge clk);
            if (tick_a) begin
                if (xpos_a == 16'd641) begin ok = 1'b1; break; end
                seen++;
                tmp = xpos_a - 16'd1;
                if (red_a != tmp[3:0] || von_a != 1'b1) bad++;
            end
        end
        check("align end", int'(ok), 1);
        check("align pixels", seen, 640);
        check("align mismatches", bad, 0);
        check("align blank red", int'(red_a), 0);
        align = 1'b0;

        // frame period on the small instance
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (fs_b) begin ok = 1'b1; break; end
        end
        check("fs first seen", int'(ok), 1);
        check("fs xpos", int'(xpos_b), 15);
        check("fs ypos", int'(ypos_b), 11);
        check("fs tick", int'(tick_b), 1);
        cnt = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            cnt++;
            if (fs_b) break;
        end
        check("fs period clk", cnt, 384);
        @(negedge clk);
        check("fs one cycle", int'(fs_b), 0);

        // vsync: low for two full lines, lagging Ypos=8 by one pixel
        wait_pix(1'b1, 0, 8, 500, ok);
        check("vs pre reached", int'(ok), 1);
        check("vs pre level", int'(vs_b), 1);
        wait_pix(1'b1, 1, 8, 10, ok);
        check("vs fall reached", int'(ok), 1);
        check("vs fall level", int'(vs_b), 0);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tick_b) begin
                if (vs_b == 1'b0) cnt++;
                else break;
            end
        end
        check("vs low pixels", cnt, 32);
        check("vs rise xpos", int'(xpos_b), 1);
        check("vs rise ypos", int'(ypos_b), 10);

        for (int i = 0; i < 8; i++) run_vec(1'b1, vb[i], $sformatf("B%0d", i));

        // mid-frame reset while both syncs are asserted
        wait_pix(1'b1, 12, 8, 500, ok);
        check("mid reached", int'(ok), 1);
        check("mid hsync pre", int'(hs_b), 0);
        check("mid vsync pre", int'(vs_b), 0);
        rst_n = 1'b0;
        #1;
        check("mid hsync rst", int'(hs_b), 1);
        check("mid vsync rst", int'(vs_b), 1);
        check("mid xpos rst",  int'(xpos_b), 0);
        check("mid ypos rst",  int'(ypos_b), 0);
        check("mid video rst", int'(von_b), 0);
        check("mid a xpos rst", int'(xpos_a), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel xpos 0", int'(xpos_b), 0);
        @(negedge clk);
        @(negedge clk);
        check("rel xpos 1", int'(xpos_b), 1);
        check("rel ypos",   int'(ypos_b), 0);
        check("rel video",  int'(von_b), 1);
        check("rel red",    int'(red_b), 10);
        check("rel hsync",  int'(hs_b), 1);
        check("rel vsync",  int'(vs_b), 1);
        check("rel a xpos", int'(xpos_a), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
